// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// First-word fall-through FIFO of fetched {pc, inst} entries with push/pop/flush.
// Pointers carry an extra wrap bit; occupancy is held in its own counter.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic         valid,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign valid      = (count_q != '0);
  assign count      = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC owner, credit-limited sequential issue to a 1-cycle instruction SRAM, and output queue.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              ADDR_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    im_req,
  output logic [ADDR_W-1:0]       im_addr,
  input  logic [INST_W-1:0]       im_rdata,
  input  logic                    redirect,
  input  logic [PC_W-1:0]         redirect_pc,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [PC_W-1:0]         out_pc,
  output logic [INST_W-1:0]       out_inst,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW:0]     credit_used;
  logic            issue, resp_valid;
  logic            fifo_push, fifo_pop, fifo_valid;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    resp_entry, head_entry;

  // Credit ignores a same-cycle pop, so a response always finds a free slot.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue       = !rst && !redirect && (credit_used < CREDIT_MAX);
  assign resp_valid  = inflight_q && !redirect;
  assign resp_entry  = '{pc: inflight_pc_q, inst: im_rdata};

  assign im_req  = issue;
  assign im_addr = fetch_pc_q[ADDR_W-1:0];
  assign count   = fifo_count;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      inflight_pc_d = fetch_pc_q;
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  always_comb begin
    fifo_push = resp_valid;
    out_valid = !rst && fifo_valid;
    out_pc    = head_entry.pc;
    out_inst  = head_entry.inst;
`ifdef IFQ_BYPASS_EN
    if (!fifo_valid && resp_valid) begin
      out_valid = !rst;
      out_pc    = resp_entry.pc;
      out_inst  = resp_entry.inst;
      fifo_push = !out_ready;
    end
`endif
    fifo_pop = fifo_valid && out_valid && out_ready && !redirect;
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (fifo_push),
    .push_entry (resp_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .valid      (fifo_valid),
    .count      (fifo_count)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed cycle table plus randomized traffic against a program-order model.
module tb_inst_fetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 16;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, im_req, redirect, out_ready, out_valid;
  logic [15:0] im_addr;
  logic [31:0] im_rdata, redirect_pc, out_pc, out_inst;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  // Synchronous-read instruction memory: data one cycle after the request.
  always @(posedge clk) im_rdata <= im_req ? inst_of(im_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          req;
    logic [15:0] addr;
    bit          vld;
    logic [31:0] pc;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy,
                     input bit req, input logic [15:0] addr, input bit vld,
                     input logic [31:0] pc, input int cnt);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    //   rst redir rpc           rdy | req addr      vld pc            cnt
    row(1, 0, 32'h0,          0,  0, 16'h0000, 0, 32'h0,         0);
    row(0, 0, 32'h0,          0,  1, 16'h0000, 0, 32'h0,         0);
    row(0, 0, 32'h0,          0,  1, 16'h0004, 0, 32'h0,         0);
    row(0, 0, 32'h0,          0,  1, 16'h0008, 1, 32'h0,         1);
    row(0, 0, 32'h0,          0,  1, 16'h000c, 1, 32'h0,         2);
    row(0, 0, 32'h0,          0,  0, 16'h0010, 1, 32'h0,         3);
    row(0, 0, 32'h0,          0,  0, 16'h0010, 1, 32'h0,         4);
    row(0, 0, 32'h0,          1,  0, 16'h0010, 1, 32'h0,         4);
    row(0, 0, 32'h0,          1,  1, 16'h0010, 1, 32'h4,         3);
    row(0, 0, 32'h0,          1,  1, 16'h0014, 1, 32'h8,         2);
    row(0, 1, 32'h100,        1,  0, 16'h0018, 1, 32'hc,         2);
    row(0, 0, 32'h0,          1,  1, 16'h0100, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0104, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0108, 1, 32'h100,       1);
    row(0, 0, 32'h0,          1,  1, 16'h010c, 1, 32'h104,       1);
    row(0, 1, 32'hFFFF_FFFC,  1,  0, 16'h0110, 1, 32'h108,       1);
    row(0, 0, 32'h0,          1,  1, 16'hfffc, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0000, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0004, 1, 32'hFFFF_FFFC, 1);
    row(0, 0, 32'h0,          1,  1, 16'h0008, 1, 32'h0,         1);
    row(0, 0, 32'h0,          0,  1, 16'h000c, 1, 32'h4,         1);
    row(0, 0, 32'h0,          0,  1, 16'h0010, 1, 32'h4,         2);
    row(0, 0, 32'h0,          0,  0, 16'h0014, 1, 32'h4,         3);
    row(0, 0, 32'h0,          0,  0, 16'h0014, 1, 32'h4,         4);
    row(1, 0, 32'h0,          0,  0, 16'h0014, 0, 32'h0,         4);
    row(0, 0, 32'h0,          0,  1, 16'h0000, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0004, 0, 32'h0,         0);
    row(0, 0, 32'h0,          1,  1, 16'h0008, 1, 32'h0,         1);
  endtask

  task automatic check_row(input int i, input vec_t v);
    $display("vec %0d: req=%0b addr=%h vld=%0b pc=%h cnt=%0d", i, im_req, im_addr, out_valid, out_pc, count);
    chk($sformatf("v%0d im_req", i), 32'(im_req), 32'(v.req));
    chk($sformatf("v%0d im_addr", i), 32'(im_addr), 32'(v.addr));
    chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v.vld));
    chk($sformatf("v%0d count", i), 32'(count), 32'(v.cnt));
    if (v.vld) begin
      chk($sformatf("v%0d out_pc", i), out_pc, v.pc);
      chk($sformatf("v%0d out_inst", i), out_inst, inst_of(v.pc[15:0]));
    end
  endtask

  // Program-order model: after reset/redirect to X, fetches and deliveries run X, X+4, ...
  bit          model_ok = 1'b0;
  logic [31:0] m_fetch, m_head;
  bit          m_req_prev;
  int          m_stored;

  task automatic model_step(input int c);
    bit exp_req, exp_vld;
    if (rst) begin
      chk($sformatf("r%0d rst im_req", c), 32'(im_req), 32'd0);
      chk($sformatf("r%0d rst out_valid", c), 32'(out_valid), 32'd0);
      if (model_ok) chk($sformatf("r%0d rst count", c), 32'(count), 32'(m_stored));
      m_fetch = RESET_PC; m_head = RESET_PC; m_req_prev = 1'b0; m_stored = 0;
      model_ok = 1'b1;
      return;
    end
    exp_req = !redirect && ((m_stored + int'(m_req_prev)) < DEPTH);
    exp_vld = (m_stored > 0) || (BYP && m_req_prev && !redirect);
    chk($sformatf("r%0d im_req", c), 32'(im_req), 32'(exp_req));
    chk($sformatf("r%0d im_addr", c), 32'(im_addr), 32'(m_fetch[15:0]));
    chk($sformatf("r%0d out_valid", c), 32'(out_valid), 32'(exp_vld));
    chk($sformatf("r%0d count", c), 32'(count), 32'(m_stored));
    if (exp_vld) begin
      chk($sformatf("r%0d out_pc", c), out_pc, m_head);
      chk($sformatf("r%0d out_inst", c), out_inst, inst_of(m_head[15:0]));
    end
    if (redirect) begin
      m_fetch = redirect_pc; m_head = redirect_pc; m_req_prev = 1'b0; m_stored = 0;
    end else begin
      if (m_req_prev) m_stored++;
      if (exp_vld && out_ready) begin
        m_stored--;
        m_head = m_head + 32'd4;
      end
      if (exp_req) m_fetch = m_fetch + 32'd4;
      m_req_prev = exp_req;
    end
  endtask

  initial begin
    bit got;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

`ifndef IFQ_BYPASS_EN
    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      @(negedge clk);
      check_row(i, vecs[i]);
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = (c == 0) || ($urandom_range(0, 199) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      out_ready = ((c % 100) < 15) ? 1'b0 : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      model_step(c);
    end

    @(posedge clk); #1;
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("liveness out_valid", 32'(got), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
